// File: rtl/arm_pipe_pkg.sv
// Shared types for the ARM 5-stage pipeline control logic.
package arm_pipe_pkg;

  localparam int NUM_REGS = 16;

  typedef logic [$clog2(NUM_REGS)-1:0] reg_idx_t;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } pipe_ctrl_state_t;

endpackage

// File: rtl/mem_wait_fsm.sv
// Multi-cycle data-memory wait tracker: FSM, wait watchdog and sticky mem_err.
// mem_stall_o is combinational so the pipeline freezes in the same cycle the access misses.
module mem_wait_fsm
  import arm_pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic mem_req_i,
  input  logic mem_ready_i,
  output logic mem_stall_o,
  output logic mem_err_o
);

  localparam int WCW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

  pipe_ctrl_state_t state_q;
  logic [WCW-1:0]   wait_cnt_q;
  logic             mem_err_q;
  logic             timeout_hit;

  assign timeout_hit = (state_q == MEM_WAIT) && (wait_cnt_q == WAIT_LAST);

  assign mem_stall_o = ((state_q == RUN) && mem_req_i && !mem_ready_i) ||
                       ((state_q == MEM_WAIT) && !mem_ready_i && !timeout_hit);
  assign mem_err_o   = mem_err_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (mem_req_i && !mem_ready_i) begin
            state_q    <= MEM_WAIT;
            wait_cnt_q <= '0;
          end
        end
        MEM_WAIT: begin
          // A timeout releases the pipeline exactly as a ready would, but flags the error.
          if (mem_ready_i) begin
            state_q <= RUN;
          end else if (timeout_hit) begin
            state_q   <= RUN;
            mem_err_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + WCW'(1);
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline freeze/flush controller for the 5-stage ARM core.
// Define FORWARDING_EN when a forwarding unit exists: only load-use hazards then stall.
module pipe_hazard_ctrl
  import arm_pipe_pkg::*;
#(
  parameter int REG_AW      = 4,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_two_src,
  input  logic              id_src1_valid,
  input  logic [REG_AW-1:0] exe_dest,
  input  logic              exe_wb_en,
  input  logic              exe_mem_read,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic              mem_wb_en,
  input  logic              branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              freeze_front,
  output logic              freeze_back,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic             mem_stall;
  logic             raw_exe;
  logic             raw_mem;
  logic             data_hazard;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  mem_wait_fsm #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_wait (
    .clk_i       (clk),
    .rst_ni      (rst),
    .mem_req_i   (mem_req),
    .mem_ready_i (mem_ready),
    .mem_stall_o (mem_stall),
    .mem_err_o   (mem_err)
  );

  assign raw_exe = exe_wb_en && ((id_src1_valid && (id_src1 == exe_dest)) ||
                                 (id_two_src && (id_src2 == exe_dest)));
  assign raw_mem = mem_wb_en && ((id_src1_valid && (id_src1 == mem_dest)) ||
                                 (id_two_src && (id_src2 == mem_dest)));

`ifdef FORWARDING_EN
  assign data_hazard = raw_exe && exe_mem_read;
`else
  assign data_hazard = raw_exe || raw_mem;
`endif

  // A held branch_taken flushes only once the memory stall lets the pipeline advance.
  always_comb begin
    freeze_front = 1'b0;
    freeze_back  = 1'b0;
    flush_ifid   = 1'b0;
    flush_idex   = 1'b0;
    if (mem_stall) begin
      freeze_front = 1'b1;
      freeze_back  = 1'b1;
    end else if (branch_taken) begin
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end else if (data_hazard) begin
      freeze_front = 1'b1;
      flush_idex   = 1'b1;
    end
  end

  assign stall_cnt_d = (freeze_front && (stall_cnt_q != {CNT_W{1'b1}})) ?
                       stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  assign stall_cnt   = stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (small timeout and counter width).
module tb_pipe_hazard_ctrl;
  import arm_pipe_pkg::*;

  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 4;

  // Data-hazard vectors; expected {freeze_front, freeze_back, flush_ifid, flush_idex}.
  localparam logic [3:0] RV_S1   [8] = '{4'd3, 4'd3, 4'd3, 4'd0, 4'd0, 4'd3, 4'd3, 4'd0};
  localparam logic       RV_V1   [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam logic [3:0] RV_S2   [8] = '{4'd0, 4'd0, 4'd0, 4'd5, 4'd5, 4'd0, 4'd0, 4'd0};
  localparam logic       RV_TWO  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [3:0] RV_ED   [8] = '{4'd3, 4'd3, 4'd3, 4'd5, 4'd5, 4'd7, 4'd3, 4'd0};
  localparam logic       RV_EWB  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam logic       RV_ERD  [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam logic [3:0] RV_MD   [8] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd3, 4'd9, 4'd0};
  localparam logic       RV_MWB  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam logic [3:0] EXP_DEF [8] = '{4'h9, 4'h9, 4'h0, 4'h9, 4'h0, 4'h9, 4'h0, 4'h0};
  localparam logic [3:0] EXP_FWD [8] = '{4'h0, 4'h9, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [3:0]       id_src1 = '0, id_src2 = '0, exe_dest = '0, mem_dest = '0;
  logic             id_two_src = 1'b0, id_src1_valid = 1'b0;
  logic             exe_wb_en = 1'b0, exe_mem_read = 1'b0, mem_wb_en = 1'b0;
  logic             branch_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
  logic             freeze_front, freeze_back, flush_ifid, flush_idex, mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [3:0]       ctl;

  int               errors = 0;
  int               checks = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .REG_AW      (4),
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .id_src1       (id_src1),
    .id_src2       (id_src2),
    .id_two_src    (id_two_src),
    .id_src1_valid (id_src1_valid),
    .exe_dest      (exe_dest),
    .exe_wb_en     (exe_wb_en),
    .exe_mem_read  (exe_mem_read),
    .mem_dest      (mem_dest),
    .mem_wb_en     (mem_wb_en),
    .branch_taken  (branch_taken),
    .mem_req       (mem_req),
    .mem_ready     (mem_ready),
    .freeze_front  (freeze_front),
    .freeze_back   (freeze_back),
    .flush_ifid    (flush_ifid),
    .flush_idex    (flush_idex),
    .mem_err       (mem_err),
    .stall_cnt     (stall_cnt)
  );

  assign ctl = {freeze_front, freeze_back, flush_ifid, flush_idex};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Apply one cycle of inputs at the falling edge; outputs settle by the #1.
  task automatic drive(input logic [3:0] s1, input logic v1, input logic [3:0] s2,
                       input logic two, input logic [3:0] ed, input logic ewb,
                       input logic erd, input logic [3:0] md, input logic mwb,
                       input logic br, input logic req, input logic rdy);
    @(negedge clk);
    id_src1 = s1; id_src1_valid = v1; id_src2 = s2; id_two_src = two;
    exe_dest = ed; exe_wb_en = ewb; exe_mem_read = erd;
    mem_dest = md; mem_wb_en = mwb; branch_taken = br;
    mem_req = req; mem_ready = rdy;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    checks++;
    if (ctl !== 4'hC) begin
      errors++; $display("FAIL reset_ctl_during_rst: got %h want %h", ctl, 4'hC);
    end
    rst = 1'b1; mem_req = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_cnt = '0;
    checks++;
    if (dut.u_mem_wait.state_q !== RUN) begin
      errors++; $display("FAIL reset_state: got %0d want %0d", dut.u_mem_wait.state_q, RUN);
    end
    checks++;
    if (stall_cnt !== exp_cnt) begin
      errors++; $display("FAIL reset_stall_cnt: got %0d want %0d", stall_cnt, exp_cnt);
    end
    checks++;
    if (mem_err !== 1'b0) begin
      errors++; $display("FAIL reset_mem_err: got %b want 0", mem_err);
    end
    checks++;
    if (ctl !== 4'h0) begin
      errors++; $display("FAIL reset_ctl_after: got %h want 0", ctl);
    end
  endtask

  task automatic test_data_hazard();
    logic [3:0] exp;
    for (int i = 0; i < 8; i++) begin
      drive(RV_S1[i], RV_V1[i], RV_S2[i], RV_TWO[i], RV_ED[i], RV_EWB[i], RV_ERD[i],
            RV_MD[i], RV_MWB[i], 0, 0, 0);
`ifdef FORWARDING_EN
      exp = EXP_FWD[i];
`else
      exp = EXP_DEF[i];
`endif
      checks++;
      if (ctl !== exp) begin
        errors++; $display("FAIL hazard_ctl[%0d]: got %h want %h", i, ctl, exp);
      end
      checks++;
      if (stall_cnt !== exp_cnt) begin
        errors++; $display("FAIL hazard_cnt[%0d]: got %0d want %0d", i, stall_cnt, exp_cnt);
      end
      if (exp[3]) exp_cnt = sat_inc(exp_cnt);
    end
  endtask

  task automatic test_branch_vs_hazard();
    drive(3, 1, 0, 0, 3, 1, 1, 3, 1, 1, 0, 0);
    checks++;
    if (ctl !== 4'h3) begin
      errors++; $display("FAIL branch_ctl: got %h want %h", ctl, 4'h3);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (stall_cnt !== exp_cnt) begin
      errors++; $display("FAIL branch_cnt: got %0d want %0d", stall_cnt, exp_cnt);
    end
  endtask

  task automatic test_mem_wait(input logic br);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, br, 1, 0);
      checks++;
      if (ctl !== 4'hC) begin
        errors++; $display("FAIL memwait_br%0d_stall[%0d]: got %h want %h", br, i, ctl, 4'hC);
      end
      exp_cnt = sat_inc(exp_cnt);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, br, 1, 1);
    checks++;
    if (ctl !== (br ? 4'h3 : 4'h0)) begin
      errors++; $display("FAIL memwait_br%0d_ready: got %h want %h", br, ctl, br ? 4'h3 : 4'h0);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (ctl !== 4'h0 || stall_cnt !== exp_cnt) begin
      errors++; $display("FAIL memwait_br%0d_after: ctl %h cnt %0d want ctl 0 cnt %0d",
                         br, ctl, stall_cnt, exp_cnt);
    end
    // Single-cycle access must not stall.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    checks++;
    if (ctl !== 4'h0) begin
      errors++; $display("FAIL memwait_br%0d_single: got %h want 0", br, ctl);
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      checks++;
      if (ctl !== 4'hC) begin
        errors++; $display("FAIL timeout_stall[%0d]: got %h want %h", i, ctl, 4'hC);
      end
      exp_cnt = sat_inc(exp_cnt);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    checks++;
    if (ctl !== 4'h0 || mem_err !== 1'b0) begin
      errors++; $display("FAIL timeout_release: ctl %h err %b want ctl 0 err 0", ctl, mem_err);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    checks++;
    if (mem_err !== 1'b1 || ctl !== 4'hC) begin
      errors++; $display("FAIL timeout_err_set: err %b ctl %h want err 1 ctl c", mem_err, ctl);
    end
    exp_cnt = sat_inc(exp_cnt);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (mem_err !== 1'b1 || stall_cnt !== exp_cnt) begin
      errors++; $display("FAIL timeout_sticky: err %b cnt %0d want err 1 cnt %0d",
                         mem_err, stall_cnt, exp_cnt);
    end
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_cnt = '0;
    checks++;
    if (mem_err !== 1'b0 || stall_cnt !== exp_cnt) begin
      errors++; $display("FAIL timeout_rst_clear: err %b cnt %0d want err 0 cnt 0",
                         mem_err, stall_cnt);
    end
  endtask

  task automatic test_reset_mid_wait();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    rst = 1'b0; mem_req = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_cnt = '0;
    checks++;
    if (dut.u_mem_wait.state_q !== RUN || ctl !== 4'h0) begin
      errors++; $display("FAIL midwait_rst: state %0d ctl %h want state %0d ctl 0",
                         dut.u_mem_wait.state_q, ctl, RUN);
    end
    checks++;
    if (stall_cnt !== exp_cnt) begin
      errors++; $display("FAIL midwait_cnt: got %0d want %0d", stall_cnt, exp_cnt);
    end
  endtask

  task automatic test_saturate();
    // Load-use hazard stalls in both builds.
    for (int i = 0; i < 20; i++) begin
      drive(3, 1, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0);
      exp_cnt = sat_inc(exp_cnt);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (stall_cnt !== {CNT_W{1'b1}} || stall_cnt !== exp_cnt) begin
      errors++; $display("FAIL saturate: got %0d want %0d", stall_cnt, exp_cnt);
    end
    drive(3, 1, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (stall_cnt !== exp_cnt) begin
      errors++; $display("FAIL saturate_hold: got %0d want %0d", stall_cnt, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_data_hazard();
    test_branch_vs_hazard();
    test_mem_wait(1'b0);
    test_mem_wait(1'b1);
    test_timeout();
    test_reset_mid_wait();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage ARM core (IF, ID, EXE, MEM, WB).
- Generates the freeze and flush controls for the PC/IF stage, the IF/ID register and the ID/EX register, using register-dependency, branch and data-memory wait information.
- Holds a small FSM for multi-cycle data-memory stalls, a timeout watchdog and a saturating stall-cycle performance counter.
- Replaces the constant hazard/branch tie-offs in the datapath top level.

Parameters:
- REG_AW, 4, register-index width (16 ARM registers).
- MEM_TIMEOUT, 64, maximum wait cycles in MEM_WAIT before mem_err is raised; must be at least 2.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-low: state is reset on a rising clk edge while rst==0.
- id_src1  in  REG_AW  ID-stage first source register (Rn).
- id_src2  in  REG_AW  ID-stage second source register (Rm, or Rd for STR).
- id_two_src  in  1  id_src2 is a real operand.
- id_src1_valid  in  1  id_src1 is a real operand (0 for MOV/MVN/branch).
- exe_dest  in  REG_AW  destination register of the instruction in EXE.
- exe_wb_en  in  1  EXE instruction writes back.
- exe_mem_read  in  1  EXE instruction is a load.
- mem_dest  in  REG_AW  destination register of the instruction in MEM.
- mem_wb_en  in  1  MEM instruction writes back.
- branch_taken  in  1  EXE resolved a taken branch.
- mem_req  in  1  MEM stage is issuing a data-memory access.
- mem_ready  in  1  data memory completes the access this cycle.
- freeze_front  out  1  hold PC, IF/ID register and ID stage.
- freeze_back  out  1  hold ID/EX, EXE/MEM and MEM/WB registers.
- flush_ifid  out  1  clear the IF/ID register.
- flush_idex  out  1  insert a bubble into ID/EX.
- mem_err  out  1  sticky memory timeout flag.
- stall_cnt  out  CNT_W  saturating count of cycles with freeze_front==1.

Behaviour:
- Reset (rst==0 at posedge):
  - state=RUN, wait counter=0, mem_err=0, stall_cnt=0.
  - All control outputs read 0 during the reset cycle and the cycle after, unless the inputs demand otherwise in RUN.
- FSM states: RUN, MEM_WAIT.
  - RUN -> MEM_WAIT when mem_req && !mem_ready.
  - MEM_WAIT -> RUN when mem_ready, or when the wait counter reaches MEM_TIMEOUT-1. On the timeout exit, mem_err is set and stays set until reset; the pipeline is released as if ready.
  - The wait counter clears on MEM_WAIT entry and increments each cycle in MEM_WAIT.
  - A single-cycle access (mem_req && mem_ready in RUN) causes no stall.
- Definitions:
  - mem_stall = (state==RUN && mem_req && !mem_ready) || (state==MEM_WAIT && !mem_ready && !timeout_hit).
  - raw_exe = exe_wb_en && ((id_src1_valid && id_src1==exe_dest) || (id_two_src && id_src2==exe_dest)).
  - raw_mem: the same test against mem_dest and mem_wb_en.
- Output priority, combinational from state and inputs (zero latency):
  1. mem_stall: freeze_front=1, freeze_back=1, flush_ifid=0, flush_idex=0. A branch_taken held in EXE is deferred and flushes in the first cycle the pipeline advances.
  2. branch_taken: flush_ifid=1, flush_idex=1, no freeze. The data hazard is ignored because the ID instruction is discarded.
  3. data_hazard: freeze_front=1, flush_idex=1 (bubble), freeze_back=0.
  4. Otherwise all outputs are 0.
- data_hazard is defined by the optional feature below.
- stall_cnt increments on every cycle with freeze_front==1 and saturates at all-ones. It is never reset mid-run except by rst.
- Reset asserted mid-MEM_WAIT returns to RUN immediately; mem_err clears.

Optional Feature:
- FORWARDING_EN defined:
  - A forwarding unit exists; data_hazard = raw_exe && exe_mem_read (load-use only).
  - raw_mem never stalls.
- FORWARDING_EN undefined:
  - data_hazard = raw_exe || raw_mem.
  - exe_mem_read is ignored.

Decomposition:
- Shared package arm_pipe_pkg holds:
  - typedef reg_idx_t (REG_AW bits);
  - enum pipe_ctrl_state_t {RUN, MEM_WAIT};
  - constant NUM_REGS=16.
- Natural sub-module: mem_wait_fsm. It contains the FSM, wait counter and mem_err, and exports mem_stall.
- Hazard compare and output priority stay in the top module.

Test Plan:
- Reset: hold rst=0 for 2 cycles with mem_req=1, mem_ready=0 -> state RUN, stall_cnt=0, mem_err=0 after release.
- RAW, no forwarding: id_src1=3, id_src1_valid=1, exe_dest=3, exe_wb_en=1 -> freeze_front=1, flush_idex=1, freeze_back=0. With FORWARDING_EN defined, the same stimulus gives all 0; adding exe_mem_read=1 gives a stall.
- Branch vs hazard: branch_taken=1 together with the RAW above -> flush_ifid=1, flush_idex=1, freeze_front=0, stall_cnt unchanged.
- Memory wait: mem_req=1 with mem_ready=0 for 3 cycles, then 1 -> freeze_front and freeze_back high for 3 cycles, 0 on the ready cycle; stall_cnt +=3.
- Deferred branch: branch_taken=1 throughout the same 3-cycle memory wait -> no flush during the wait; flush_ifid and flush_idex=1 on the ready cycle.
- Timeout: MEM_TIMEOUT=4, mem_ready stuck at 0 -> freeze for 4 cycles, then released; mem_err=1 stays set until rst=0. Also preload stall_cnt near all-ones and check it saturates.
